// File: rtl/apb_pkg.sv
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared types and constants for the APB5 requester and checkers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int unsigned C_PPROT_PRIV_BIT  = 0;
    localparam int unsigned C_PPROT_NSEC_BIT  = 1;
    localparam int unsigned C_PPROT_INSTR_BIT = 2;

    localparam int unsigned C_DEFAULT_TIMEOUT = 16;

endpackage

`default_nettype wire

// File: rtl/apb_parity_gen.sv
// ============================================================================
// Module   : apb_parity_gen
// Brief    : Even parity over the APB5 request fields; shared with completers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_parity_gen #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int USER_REQ_WIDTH  = 8,
    parameter int USER_DATA_WIDTH = DATA_WIDTH / 2
) (
    input  logic [ADDR_WIDTH-1:0]      addr_i,
    input  logic                       write_i,
    input  logic [STRB_WIDTH-1:0]      strb_i,
    input  logic [2:0]                 prot_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic [USER_REQ_WIDTH-1:0]  auser_i,
    input  logic [USER_DATA_WIDTH-1:0] wuser_i,
    output logic                       parity_o
);

    // Field order matches the concatenation the completer checks against.
    assign parity_o = ^{addr_i, write_i, strb_i, prot_i, wdata_i, auser_i, wuser_i};

endmodule

`default_nettype wire

// File: rtl/apb_requester.sv
// ============================================================================
// Module   : apb_requester
// Brief    : valid/ready command channel to APB5 SETUP/ACCESS bridge with
//            parity, wakeup and PREADY timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_REQ_WIDTH  = 8,
    parameter int USER_DATA_WIDTH = DATA_WIDTH / 2,
    parameter int USER_RESP_WIDTH = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES  = C_DEFAULT_TIMEOUT
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic [DATA_WIDTH-1:0]      cmd_wdata,
    input  logic [STRB_WIDTH-1:0]      cmd_strb,
    input  logic [2:0]                 cmd_prot,
    input  logic [USER_REQ_WIDTH-1:0]  cmd_auser,
    input  logic [USER_DATA_WIDTH-1:0] cmd_wuser,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic [USER_DATA_WIDTH-1:0] rsp_ruser,
    output logic [USER_RESP_WIDTH-1:0] rsp_buser,
    output logic                       rsp_slverr,
    output logic                       rsp_parerr,
    output logic                       rsp_timeout,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_WIDTH-1:0]      PADDR,
    output logic [DATA_WIDTH-1:0]      PWDATA,
    output logic [STRB_WIDTH-1:0]      PSTRB,
    output logic [2:0]                 PPROT,
    output logic                       PWAKEUP,
    output logic [USER_REQ_WIDTH-1:0]  PAUSER,
    output logic [USER_DATA_WIDTH-1:0] PWUSER,
    output logic                       PPARITY,
    input  logic [DATA_WIDTH-1:0]      PRDATA,
    input  logic [USER_DATA_WIDTH-1:0] PRUSER,
    input  logic [USER_RESP_WIDTH-1:0] PBUSER,
    input  logic                       PREADY,
    input  logic                       PSLVERR,
    input  logic                       PPARERR
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           tmo_cnt_q, tmo_cnt_d;

    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic                       pwakeup_q, pwakeup_d;
    logic                       pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]      paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]      pstrb_q, pstrb_d;
    logic [2:0]                 pprot_q, pprot_d;
    logic [USER_REQ_WIDTH-1:0]  pauser_q, pauser_d;
    logic [USER_DATA_WIDTH-1:0] pwuser_q, pwuser_d;
    logic                       pparity_q, pparity_d;

    logic                       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [USER_DATA_WIDTH-1:0] rsp_ruser_q, rsp_ruser_d;
    logic [USER_RESP_WIDTH-1:0] rsp_buser_q, rsp_buser_d;
    logic                       rsp_slverr_q, rsp_slverr_d;
    logic                       rsp_parerr_q, rsp_parerr_d;
    logic                       rsp_timeout_q, rsp_timeout_d;

    logic [DATA_WIDTH-1:0]      w_wdata;
    logic [STRB_WIDTH-1:0]      w_strb;
    logic                       w_parity;
    logic                       w_tmo_hit;

    // Reads carry no write payload, and parity must cover the zeroed fields.
    assign w_wdata   = cmd_write ? cmd_wdata : '0;
    assign w_strb    = cmd_write ? cmd_strb  : '0;
    assign w_tmo_hit = (tmo_cnt_q == C_TMO_LAST);

    apb_parity_gen #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .STRB_WIDTH      (STRB_WIDTH),
        .USER_REQ_WIDTH  (USER_REQ_WIDTH),
        .USER_DATA_WIDTH (USER_DATA_WIDTH)
    ) u_parity (
        .addr_i   (cmd_addr),
        .write_i  (cmd_write),
        .strb_i   (w_strb),
        .prot_i   (cmd_prot),
        .wdata_i  (w_wdata),
        .auser_i  (cmd_auser),
        .wuser_i  (cmd_wuser),
        .parity_o (w_parity)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid)            state_d = SETUP;
            SETUP:                             state_d = ACCESS;
            ACCESS:  if (PREADY || w_tmo_hit)  state_d = RESP;
            RESP:    if (rsp_ready)            state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        pauser_d      = pauser_q;
        pwuser_d      = pwuser_q;
        pparity_d     = pparity_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_ruser_d   = rsp_ruser_q;
        rsp_buser_d   = rsp_buser_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_parerr_d  = rsp_parerr_q;
        rsp_timeout_d = rsp_timeout_q;
        tmo_cnt_d     = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = w_wdata;
                    pstrb_d   = w_strb;
                    pprot_d   = cmd_prot;
                    pauser_d  = cmd_auser;
                    pwuser_d  = cmd_wuser;
                    pparity_d = w_parity;
                end
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_ruser_d   = PRUSER;
                    rsp_buser_d   = PBUSER;
                    rsp_slverr_d  = PSLVERR;
                    rsp_parerr_d  = PPARERR;
                    rsp_timeout_d = 1'b0;
                end else if (w_tmo_hit) begin
                    rsp_rdata_d   = '0;
                    rsp_ruser_d   = '0;
                    rsp_buser_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_parerr_d  = 1'b0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Handshake outputs are registered copies of the upcoming state.
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        pwakeup_d   = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q     <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwakeup_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            pauser_q      <= '0;
            pwuser_q      <= '0;
            pparity_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_ruser_q   <= '0;
            rsp_buser_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_parerr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwakeup_q     <= pwakeup_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            pauser_q      <= pauser_d;
            pwuser_q      <= pwuser_d;
            pparity_q     <= pparity_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_ruser_q   <= rsp_ruser_d;
            rsp_buser_q   <= rsp_buser_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_parerr_q  <= rsp_parerr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWAKEUP     = pwakeup_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;
    assign PAUSER      = pauser_q;
    assign PWUSER      = pwuser_q;
    assign PPARITY     = pparity_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_ruser   = rsp_ruser_q;
    assign rsp_buser   = rsp_buser_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_parerr  = rsp_parerr_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_requester.sv
// ============================================================================
// Module   : tb_apb_requester
// Brief    : Randomised bench with a companion completer and transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_requester;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int RW  = 8;
    localparam int UW  = 16;
    localparam int BW  = 16;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic [2:0]    cmd_prot;
    logic [RW-1:0] cmd_auser;
    logic [UW-1:0] cmd_wuser;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [UW-1:0] rsp_ruser;
    logic [BW-1:0] rsp_buser;
    logic          rsp_slverr, rsp_parerr, rsp_timeout;
    logic          PSEL, PENABLE, PWRITE, PWAKEUP, PPARITY;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [2:0]    PPROT;
    logic [RW-1:0] PAUSER;
    logic [UW-1:0] PWUSER;
    logic [DW-1:0] PRDATA;
    logic [UW-1:0] PRUSER;
    logic [BW-1:0] PBUSER;
    logic          PREADY, PSLVERR, PPARERR;

    always #5 PCLK = ~PCLK;

    apb_requester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_REQ_WIDTH(RW), .USER_DATA_WIDTH(UW),
        .USER_RESP_WIDTH(BW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .cmd_auser(cmd_auser), .cmd_wuser(cmd_wuser),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_ruser(rsp_ruser), .rsp_buser(rsp_buser), .rsp_slverr(rsp_slverr),
        .rsp_parerr(rsp_parerr), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PWAKEUP(PWAKEUP),
        .PAUSER(PAUSER), .PWUSER(PWUSER), .PPARITY(PPARITY),
        .PRDATA(PRDATA), .PRUSER(PRUSER), .PBUSER(PBUSER),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PPARERR(PPARERR)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        logic [RW-1:0] auser;
        logic [UW-1:0] wuser;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic [UW-1:0] ruser;
        logic [BW-1:0] buser;
        logic          slverr;
        logic          parerr;
        logic          tmo;
    } rsp_t;

    int   checks   = 0;
    int   failures = 0;
    req_t cur;
    bit   cur_valid = 1'b0;
    rsp_t exp_q[$];
    rsp_t got;
    int   last_psel_k, last_pen_k, last_rsp_k;
    logic last_par;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=1 required=0", name);
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < SW; i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic logic mpar(input req_t r);
        logic [SW-1:0] s;
        logic [DW-1:0] d;
        s = r.wr ? r.strb : '0;
        d = r.wr ? r.wdata : '0;
        return ^{r.addr, r.wr, s, r.prot, d, r.auser, r.wuser};
    endfunction

    // ---------------- companion completer ----------------
    logic [DW-1:0] mem  [logic [AW-1:0]];
    logic [UW-1:0] umem [logic [AW-1:0]];
    int comp_wait  = 0;
    bit comp_stuck = 1'b0;
    bit comp_flip  = 1'b0;
    int acc_cnt    = 0;

    always @(negedge PCLK) begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PRUSER  = UW'($urandom);
        PBUSER  = BW'($urandom);
        PSLVERR = 1'(($urandom));
        PPARERR = 1'(($urandom));
        if (PRESETn && PSEL && PENABLE) begin
            if (!comp_stuck && acc_cnt == comp_wait) begin
                PREADY  = 1'b1;
                acc_cnt = 0;
                PSLVERR = (PADDR[11:8] == 4'hE);
                PPARERR = ((PPARITY ^ comp_flip) != ^{PADDR, PWRITE, PSTRB, PPROT, PWDATA, PAUSER, PWUSER});
                PBUSER  = BW'(PAUSER);
                if (PWRITE) begin
                    PRUSER = ~PWUSER;
                    if (!PSLVERR) begin
                        mem[PADDR]  = merge(mem.exists(PADDR) ? mem[PADDR] : '0, PWDATA, PSTRB);
                        umem[PADDR] = PWUSER;
                    end
                end else begin
                    PRDATA = mem.exists(PADDR) ? mem[PADDR] : '0;
                    PRUSER = umem.exists(PADDR) ? umem[PADDR] : '0;
                end
            end else begin
                acc_cnt++;
            end
        end else begin
            acc_cnt = 0;
        end
    end

    // ---------------- reference model of responses ----------------
    logic [DW-1:0] ref_mem  [logic [AW-1:0]];
    logic [UW-1:0] ref_umem [logic [AW-1:0]];

    function automatic rsp_t predict(input req_t r, input bit stuck, input bit flip);
        rsp_t e;
        e = '0;
        if (stuck) begin
            e.slverr = 1'b1;
            e.tmo    = 1'b1;
        end else begin
            e.slverr = (r.addr[11:8] == 4'hE);
            e.parerr = flip;
            e.buser  = BW'(r.auser);
            if (r.wr) begin
                e.ruser = ~r.wuser;
                if (!e.slverr) begin
                    ref_mem[r.addr]  = merge(ref_mem.exists(r.addr) ? ref_mem[r.addr] : '0, r.wdata, r.strb);
                    ref_umem[r.addr] = r.wuser;
                end
            end else begin
                e.rdata = ref_mem.exists(r.addr) ? ref_mem[r.addr] : '0;
                e.ruser = ref_umem.exists(r.addr) ? ref_umem[r.addr] : '0;
            end
        end
        return e;
    endfunction

    // ---------------- per-cycle compare ----------------
    bit prev_psel = 1'b0;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            chk("rst_psel", PSEL, 0);
            chk("rst_penable", PENABLE, 0);
            chk("rst_pwakeup", PWAKEUP, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_paddr", PADDR, 0);
            chk("rst_rsp", {rsp_rdata, rsp_ruser, rsp_buser, rsp_slverr, rsp_parerr, rsp_timeout}, 0);
            prev_psel = 1'b0;
        end else begin
            chk("cmd_ready", cmd_ready, !(PSEL || rsp_valid));
            chk("pwakeup", PWAKEUP, PSEL || rsp_valid);
            chk("psel_rsp_overlap", PSEL && rsp_valid, 0);
            if (PSEL) begin
                if (!cur_valid) begin
                    fail_now("psel_without_cmd");
                end else begin
                    chk("penable", PENABLE, prev_psel);
                    chk("paddr", PADDR, cur.addr);
                    chk("pwrite", PWRITE, cur.wr);
                    chk("pwdata", PWDATA, cur.wr ? cur.wdata : '0);
                    chk("pstrb", PSTRB, cur.wr ? cur.strb : '0);
                    chk("pprot", PPROT, cur.prot);
                    chk("pauser", PAUSER, cur.auser);
                    chk("pwuser", PWUSER, cur.wuser);
                    chk("pparity", PPARITY, mpar(cur));
                end
            end else begin
                chk("penable_idle", PENABLE, 0);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("rsp_without_cmd");
                end else begin
                    chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    chk("rsp_slverr", rsp_slverr, exp_q[0].slverr);
                    chk("rsp_timeout", rsp_timeout, exp_q[0].tmo);
                    if (!exp_q[0].tmo) begin
                        chk("rsp_ruser", rsp_ruser, exp_q[0].ruser);
                        chk("rsp_buser", rsp_buser, exp_q[0].buser);
                        chk("rsp_parerr", rsp_parerr, exp_q[0].parerr);
                    end
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            prev_psel = PSEL;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_cmd(input req_t r);
        int k;
        cur       = r;
        cur_valid = 1'b1;
        cmd_write = r.wr;
        cmd_addr  = r.addr;
        cmd_wdata = r.wdata;
        cmd_strb  = r.strb;
        cmd_prot  = r.prot;
        cmd_auser = r.auser;
        cmd_wuser = r.wuser;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(posedge PCLK); #1;
            k++;
        end
        if (!cmd_ready) fail_now("cmd_accept_timeout");
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = 1'($urandom);
        cmd_wuser = UW'($urandom);
    endtask

    task automatic run_txn(input req_t r, input int waitc, input bit stuck, input bit flip,
                           input int hold, input bit early);
        int k;
        @(posedge PCLK); #1;
        comp_wait  = waitc;
        comp_stuck = stuck;
        comp_flip  = flip;
        rsp_ready  = early && (hold == 0);
        exp_q.push_back(predict(r, stuck, flip));
        issue_cmd(r);
        k = 0;
        last_psel_k = -1; last_pen_k = -1; last_rsp_k = -1;
        while (last_rsp_k < 0 && k < 100) begin
            @(negedge PCLK);
            k++;
            if (k == 1) last_par = PPARITY;
            if (PSEL && last_psel_k < 0) last_psel_k = k;
            if (PENABLE && last_pen_k < 0) last_pen_k = k;
            if (rsp_valid) last_rsp_k = k;
        end
        got = {rsp_rdata, rsp_ruser, rsp_buser, rsp_slverr, rsp_parerr, rsp_timeout};
        chk("lat_psel", last_psel_k, 1);
        chk("lat_penable", last_pen_k, 2);
        chk("lat_rsp", last_rsp_k, stuck ? 2 + TMO : 3 + waitc);
        chk("psel_in_resp", PSEL, 0);
        if (!rsp_ready) begin
            repeat ((hold > 0) ? hold : 1) @(posedge PCLK);
            #1;
            rsp_ready = 1'b1;
        end
        @(posedge PCLK); #1;
        chk("rsp_drop", rsp_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
        cur_valid  = 1'b0;
        comp_stuck = 1'b0;
        comp_flip  = 1'b0;
        rsp_ready  = 1'($urandom);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=expired required=finished");
        $fatal(1);
    end

    initial begin
        req_t r;
        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        cmd_prot = '0; cmd_auser = '0; cmd_wuser = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        chk("init_cmd_ready", cmd_ready, 1);

        // Zero-wait write, then read back.
        r = '0;
        r.wr = 1'b1; r.addr = 32'h10; r.wdata = 32'hCAFEF00D; r.strb = 4'hF;
        r.auser = 8'h81; r.wuser = 16'h005A;
        run_txn(r, 0, 0, 0, 0, 1);
        chk("w1_lat_rsp", last_rsp_k, 3);
        chk("w1_slverr", got.slverr, 0);
        chk("w1_rdata", got.rdata, 0);
        chk("w1_parity", last_par, 0);

        r.wr = 1'b0; r.wdata = 32'h12345678; r.strb = 4'hA;
        run_txn(r, 0, 0, 0, 0, 1);
        chk("r1_rdata", got.rdata, 32'hCAFEF00D);
        chk("r1_ruser", got.ruser, 16'h005A);
        chk("r1_buser", got.buser, 16'h0081);
        chk("r1_parity", last_par, 1);

        // Three wait states.
        r = '0; r.wr = 1'b1; r.addr = 32'h20; r.wdata = $urandom; r.strb = 4'h5; r.prot = 3'd5;
        run_txn(r, 3, 0, 0, 0, 1);
        chk("wait3_lat", last_rsp_k, 6);
        chk("wait3_tmo", got.tmo, 0);

        // Stuck completer.
        r = '0; r.addr = 32'h30; r.auser = 8'h3C;
        run_txn(r, 0, 1, 0, 0, 1);
        chk("tmo_lat", last_rsp_k, 18);
        chk("tmo_slverr", got.slverr, 1);
        chk("tmo_flag", got.tmo, 1);
        chk("tmo_rdata", got.rdata, 0);

        // Corrupted parity seen by the completer.
        r = '0; r.wr = 1'b1; r.addr = 32'h44; r.wdata = $urandom; r.strb = 4'hF;
        run_txn(r, 1, 0, 1, 0, 1);
        chk("flip_parerr", got.parerr, 1);

        // Response held off for five cycles.
        r = '0; r.addr = 32'h10; r.auser = 8'h07;
        run_txn(r, 0, 0, 0, 5, 0);
        chk("hold_rdata", got.rdata, 32'hCAFEF00D);

        // Reset in the middle of ACCESS.
        @(posedge PCLK); #1;
        comp_stuck = 1'b1;
        rsp_ready  = 1'b0;
        r = '0; r.wr = 1'b1; r.addr = 32'h50; r.wdata = 32'hDEADBEEF; r.strb = 4'hF;
        issue_cmd(r);
        repeat (3) @(posedge PCLK);
        #1;
        chk("pre_rst_penable", PENABLE, 1);
        PRESETn   = 1'b0;
        cur_valid = 1'b0;
        #1;
        chk("async_rst_psel", PSEL, 0);
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn    = 1'b1;
        comp_stuck = 1'b0;
        repeat (5) @(negedge PCLK);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_pwakeup", PWAKEUP, 0);

        // Randomised sweep.
        for (int n = 0; n < 40; n++) begin
            r.wr    = 1'($urandom);
            r.addr  = (32'($urandom_range(0, 7)) << 2) | (($urandom_range(0, 9) == 0) ? 32'hE00 : 32'h0);
            r.wdata = $urandom;
            r.strb  = SW'($urandom);
            r.prot  = 3'($urandom);
            r.auser = RW'($urandom);
            r.wuser = UW'($urandom);
            run_txn(r, $urandom_range(0, 3), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 2), 1'($urandom));
        end

        repeat (3) @(negedge PCLK);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
